bandit_arbiter: RTL

Shares one `bandit` agent between `CLIENTS` environment clients. Round-robin grants a requesting client, routes the agent's action to it, then routes that client's reward back to the agent. A watchdog injects a fixed penalty reward if the client does not reply in time. Sits between the `bandit` action/reward ports and the per-environment interfaces.

---
 rtl/bandit_pkg.sv | 20 ++
 rtl/bandit_arbiter_if.sv | 58 +++++
 rtl/rr_select.sv | 33 +++
 rtl/bandit_arbiter.sv | 129 ++++++++++++
 4 files changed

// File: rtl/bandit_pkg.sv
// Shared widths and arbiter state encoding for the bandit agent
// and the client arbiter that fronts it.
package bandit_pkg;

  localparam int ACTION_WIDTH = 8;
  localparam int REWARD_WIDTH = 8;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ACTION  = 2'd1;
  localparam logic [1:0] ST_REWARD  = 2'd2;
  localparam logic [1:0] ST_PENALTY = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE    = ST_IDLE,
    S_ACTION  = ST_ACTION,
    S_REWARD  = ST_REWARD,
    S_PENALTY = ST_PENALTY
  } arb_state_t;

endpackage

// File: rtl/bandit_arbiter_if.sv
// Client-side and agent-side handshake bundle of the bandit arbiter.
// master = arbiter, slave = clients plus agent.
interface bandit_arbiter_if
  import bandit_pkg::*;
#(
  parameter int CLIENTS = 4
) ();

  logic [CLIENTS-1:0]              request;
  logic [CLIENTS-1:0]              grant;
  logic [CLIENTS-1:0]              client_action_valid;
  logic [ACTION_WIDTH-1:0]         client_action_data;
  logic [CLIENTS-1:0]              client_action_ready;
  logic [CLIENTS-1:0]              client_reward_valid;
  logic [REWARD_WIDTH*CLIENTS-1:0] client_reward_data;
  logic [CLIENTS-1:0]              client_reward_ready;
  logic                            bandit_action_valid;
  logic [ACTION_WIDTH-1:0]         bandit_action_data;
  logic                            bandit_action_ready;
  logic                            bandit_reward_valid;
  logic [REWARD_WIDTH-1:0]         bandit_reward_data;
  logic                            bandit_reward_ready;

  modport master (
    input  request,
    input  client_action_ready,
    input  client_reward_valid,
    input  client_reward_data,
    input  bandit_action_valid,
    input  bandit_action_data,
    input  bandit_reward_ready,
    output grant,
    output client_action_valid,
    output client_action_data,
    output client_reward_ready,
    output bandit_action_ready,
    output bandit_reward_valid,
    output bandit_reward_data
  );

  modport slave (
    output request,
    output client_action_ready,
    output client_reward_valid,
    output client_reward_data,
    output bandit_action_valid,
    output bandit_action_data,
    output bandit_reward_ready,
    input  grant,
    input  client_action_valid,
    input  client_action_data,
    input  client_reward_ready,
    input  bandit_action_ready,
    input  bandit_reward_valid,
    input  bandit_reward_data
  );

endinterface

// File: rtl/rr_select.sv
// Round-robin picker: first requester after the pointer, wrapping.
// Purely combinational.
module rr_select #(
  parameter int CLIENTS = 4,
  parameter int IW      = $clog2(CLIENTS)
) (
  input  logic [CLIENTS-1:0] i_request,
  input  logic [IW-1:0]      i_pointer,
  output logic [CLIENTS-1:0] o_onehot,
  output logic [IW-1:0]      o_index
);

  localparam logic [IW:0] NC = (IW+1)'(CLIENTS);

  always_comb begin
    logic        w_found;
    logic [IW:0] w_c;
    o_onehot = '0;
    o_index  = '0;
    w_found  = 1'b0;
    w_c      = '0;
    for (int i = 1; i <= CLIENTS; i++) begin
      w_c = {1'b0, i_pointer} + (IW+1)'(i);
      if (w_c >= NC) w_c = w_c - NC;
      if (!w_found && i_request[w_c[IW-1:0]]) begin
        w_found              = 1'b1;
        o_onehot[w_c[IW-1:0]] = 1'b1;
        o_index              = w_c[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/bandit_arbiter.sv
// Shares one bandit agent among several clients: round-robin grant,
// action forward, reward return, and a penalty when a reward is late.
module bandit_arbiter
  import bandit_pkg::*;
#(
  parameter int                      CLIENTS = 4,
  parameter int                      TIMEOUT = 255,
  parameter logic [REWARD_WIDTH-1:0] PENALTY = 8'h80
) (
  input  logic             clock,
  input  logic             reset,
  bandit_arbiter_if.master bus,
  output logic [7:0]       timeouts
);

  localparam int         IW  = $clog2(CLIENTS);
  localparam logic [7:0] TMO = 8'(TIMEOUT);

  arb_state_t              r_state, w_state;
  logic [CLIENTS-1:0]      r_grant, w_grant;
  logic [CLIENTS-1:0]      w_pick;
  logic [IW-1:0]           r_ptr, w_ptr, w_pick_idx;
  logic [7:0]              r_timer, w_timer;
  logic [7:0]              r_timeouts, w_timeouts;
  logic                    w_act_rdy, w_rew_vld;
  logic [REWARD_WIDTH-1:0] w_rew_data;

  rr_select #(
    .CLIENTS (CLIENTS),
    .IW      (IW)
  ) u_rr (
    .i_request (bus.request),
    .i_pointer (r_ptr),
    .o_onehot  (w_pick),
    .o_index   (w_pick_idx)
  );

  assign bus.grant              = r_grant;
  assign bus.client_action_data = bus.bandit_action_data;
  assign timeouts               = r_timeouts;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_grant    <= '0;
      r_ptr      <= IW'(CLIENTS - 1);
      r_timer    <= '0;
      r_timeouts <= '0;
    end else begin
      r_state    <= w_state;
      r_grant    <= w_grant;
      r_ptr      <= w_ptr;
      r_timer    <= w_timer;
      r_timeouts <= w_timeouts;
    end
  end

  always_comb begin
    w_state    = r_state;
    w_grant    = r_grant;
    w_ptr      = r_ptr;
    w_timer    = r_timer;
    w_timeouts = r_timeouts;
    w_act_rdy  = |(r_grant & bus.client_action_ready);
    w_rew_vld  = |(r_grant & bus.client_reward_valid);
    w_rew_data = '0;
    for (int i = 0; i < CLIENTS; i++) begin
      if (r_grant[i]) begin
        w_rew_data = bus.client_reward_data[i*REWARD_WIDTH +: REWARD_WIDTH];
      end
    end
    bus.client_action_valid = '0;
    bus.client_reward_ready = '0;
    bus.bandit_action_ready = 1'b0;
    bus.bandit_reward_valid = 1'b0;
    bus.bandit_reward_data  = '0;
    unique case (r_state)
      S_IDLE: begin
        if (|bus.request) begin
          w_state = S_ACTION;
          w_grant = w_pick;
          w_ptr   = w_pick_idx;
        end
      end
      S_ACTION: begin
        bus.client_action_valid =
          r_grant & {CLIENTS{bus.bandit_action_valid}};
        bus.bandit_action_ready = w_act_rdy;
        if (bus.bandit_action_valid && w_act_rdy) begin
          w_state = S_REWARD;
          w_timer = TMO;
        end
      end
      S_REWARD: begin
        bus.client_reward_ready =
          r_grant & {CLIENTS{bus.bandit_reward_ready}};
        bus.bandit_reward_valid = w_rew_vld;
        bus.bandit_reward_data  = w_rew_data;
        // A reply on the last budget cycle still beats the watchdog.
        if (w_rew_vld && bus.bandit_reward_ready) begin
          w_state = S_IDLE;
          w_grant = '0;
        end else if (r_timer == 8'd0) begin
          w_state = S_PENALTY;
        end else begin
          w_timer = r_timer - 8'd1;
        end
      end
      S_PENALTY: begin
        bus.bandit_reward_valid = 1'b1;
        bus.bandit_reward_data  = PENALTY;
        if (bus.bandit_reward_ready) begin
          w_state = S_IDLE;
          w_grant = '0;
          if (r_timeouts != 8'hff) w_timeouts = r_timeouts + 8'd1;
        end
      end
      default: ;
    endcase
    if (reset) begin
      bus.client_action_valid = '0;
      bus.client_reward_ready = '0;
      bus.bandit_action_ready = 1'b0;
      bus.bandit_reward_valid = 1'b0;
      bus.bandit_reward_data  = '0;
    end
  end

endmodule
